mult_div_unit: RTL and testbench

Multi-cycle signed multiply/divide unit of the multicycle MIPS datapath. Performs MULT (radix-2 Booth) and DIV (signed restoring division) on the two register-file operands over 32 iteration cycles. Holds the results in the architectural HI and LO registers, whose outputs feed the write-back data-source multiplexer for MFHI/MFLO. Driven by the control unit through a start/done handshake.

---
 rtl/mult_div_if.sv | 23 ++
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Start/done handshake between the control unit and the multiply/divide unit.
// The control unit drives the master side; the unit itself is the slave.
interface mult_div_if;
    logic        MultStart;
    logic        DivStart;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic        MultDivDone;
    logic        DivZero;
    logic        Busy;

    modport master (
        output MultStart, DivStart, A_in, B_in,
        input  HI_out, LO_out, MultDivDone, DivZero, Busy
    );

    modport slave (
        input  MultStart, DivStart, A_in, B_in,
        output HI_out, LO_out, MultDivDone, DivZero, Busy
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit that
// owns the architectural HI/LO registers. Both operations take 32 iteration
// cycles, then the unit spends one cycle in DONE pulsing MultDivDone.
module mult_div_unit (
    input  logic     clk,
    input  logic     reset,
    mult_div_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    // acc/q hold {acc, Q} for MULT and {rem, quo} for DIV; m holds the
    // multiplicand or the divisor magnitude.
    logic [31:0] acc, q, m;
    logic        q_m1;
    logic        quo_neg, rem_neg;
    logic [31:0] hi, lo;
    logic        div_zero;

    logic        last;
    logic [32:0] booth_sum;
    logic [31:0] mul_acc_nx, mul_q_nx;
    logic [31:0] rem_sh, quo_sh;
    logic [32:0] trial;
    logic [31:0] rem_nx, quo_nx;
    logic [31:0] a_mag, b_mag;

    assign last  = (cnt == 6'd31);
    assign a_mag = bus.A_in[31] ? (32'd0 - bus.A_in) : bus.A_in;
    assign b_mag = bus.B_in[31] ? (32'd0 - bus.B_in) : bus.B_in;

    // Booth step: the add/subtract is done at 33 bits so that a multiplicand
    // of 0x80000000 cannot overflow acc before the arithmetic shift.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        booth_sum = {acc[31], acc};
        case ({q[0], q_m1})
            2'b01:   booth_sum = {acc[31], acc} + {m[31], m};
            2'b10:   booth_sum = {acc[31], acc} - {m[31], m};
            default: booth_sum = {acc[31], acc};
        endcase
        mul_acc_nx = booth_sum[32:1];
        mul_q_nx   = {booth_sum[0], q[31:1]};
    end

    // Restoring division step: shift {rem, quo} left, trial-subtract the
    // divisor magnitude, keep the difference only if it did not go negative.
    always_comb begin
        rem_sh = {acc[30:0], q[31]};
        quo_sh = {q[30:0], 1'b0};
        trial  = {1'b0, rem_sh} - {1'b0, m};
        rem_nx = rem_sh;
        quo_nx = quo_sh;
        if (!trial[32]) begin
            rem_nx = trial[31:0];
            quo_nx = {q[30:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nx;
        end
    end

    // Next-state logic; starts are only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.MultStart)
                    state_nx = MULT;
                else if (bus.DivStart && (bus.B_in != 32'd0))
                    state_nx = DIV;
            end
            MULT:    if (last) state_nx = DONE;
            DIV:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, iterations, HI/LO write-back and DivZero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the working registers are reset too, so an abandoned operation leaves no stale state behind.
            cnt      <= 6'd0;
            acc      <= 32'd0;
            q        <= 32'd0;
            m        <= 32'd0;
            q_m1     <= 1'b0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MultStart) begin
                        acc  <= 32'd0;
                        q    <= bus.B_in;
                        q_m1 <= 1'b0;
                        m    <= bus.A_in;
                        cnt  <= 6'd0;
                    end else if (bus.DivStart) begin
                        if (bus.B_in != 32'd0) begin
                            acc     <= 32'd0;
                            q       <= a_mag;
                            m       <= b_mag;
                            quo_neg <= bus.A_in[31] ^ bus.B_in[31];
                            rem_neg <= bus.A_in[31];
                            cnt     <= 6'd0;
                        end else begin
                            div_zero <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc  <= mul_acc_nx;
                    q    <= mul_q_nx;
                    q_m1 <= q[0];
                    cnt  <= cnt + 6'd1;
                    if (last) begin
                        hi <= mul_acc_nx;
                        lo <= mul_q_nx;
                    end
                end
                DIV: begin
                    acc <= rem_nx;
                    q   <= quo_nx;
                    cnt <= cnt + 6'd1;
                    if (last) begin
                        hi <= rem_neg ? (32'd0 - rem_nx) : rem_nx;
                        lo <= quo_neg ? (32'd0 - quo_nx) : quo_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.HI_out      = hi;
    assign bus.LO_out      = lo;
    assign bus.MultDivDone = (state == DONE);
    assign bus.DivZero     = div_zero;
    assign bus.Busy        = (state != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed MULT/DIV results, latency,
// divide-by-zero, start priority, ignored starts and mid-operation reset.
module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mult_div_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a start for exactly one rising edge (edge k); returns #1 after it.
    task automatic start_op(input bit mul, input bit div,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.MultStart = mul;
        bus.DivStart  = div;
        bus.A_in      = a;
        bus.B_in      = b;
        @(posedge clk);
        #1;
        bus.MultStart = 1'b0;
        bus.DivStart  = 1'b0;
    endtask

    // Count edges after the start edge until MultDivDone is seen (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.MultDivDone === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input bit mul,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        start_op(mul, !mul, a, b);
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_start: got %b want 1", name, bus.Busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL %s latency: got %0d want 32", name, cyc);
        end
        checks++;
        if (bus.HI_out !== exp_hi || bus.LO_out !== exp_lo) begin
            errors++;
            $display("FAIL %s result: got HI=%h LO=%h want HI=%h LO=%h",
                     name, bus.HI_out, bus.LO_out, exp_hi, exp_lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.MultDivDone !== 1'b0) begin
            errors++;
            $display("FAIL %s end: got busy=%b done=%b want 0 0",
                     name, bus.Busy, bus.MultDivDone);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.MultStart = 1'b0;
        bus.DivStart  = 1'b0;
        bus.A_in      = 32'd0;
        bus.B_in      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.HI_out !== 32'd0 || bus.LO_out !== 32'd0 || bus.Busy !== 1'b0 ||
            bus.MultDivDone !== 1'b0 || bus.DivZero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got HI=%h LO=%h busy=%b done=%b dz=%b want all 0",
                     bus.HI_out, bus.LO_out, bus.Busy, bus.MultDivDone, bus.DivZero);
        end
    endtask

    task automatic test_mult();
        run_op("mult_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min_x_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("mult_-1x-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    endtask

    task automatic test_div();
        run_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_overflow", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_100/-7", 1'b0, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
    endtask

    // HI/LO hold 2 / 0xFFFFFFF2 from the previous division.
    task automatic test_div_zero();
        int dones;
        start_op(1'b0, 1'b1, 32'd55, 32'd0);
        checks++;
        if (bus.DivZero !== 1'b1 || bus.Busy !== 1'b0 || bus.MultDivDone !== 1'b0) begin
            errors++;
            $display("FAIL divzero_pulse: got dz=%b busy=%b done=%b want 1 0 0",
                     bus.DivZero, bus.Busy, bus.MultDivDone);
        end
        dones = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (bus.MultDivDone === 1'b1 || bus.Busy === 1'b1 || bus.DivZero === 1'b1)
                dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL divzero_after: got %0d active cycles want 0", dones);
        end
        checks++;
        if (bus.HI_out !== 32'h0000_0002 || bus.LO_out !== 32'hFFFF_FFF2) begin
            errors++;
            $display("FAIL divzero_hilo: got HI=%h LO=%h want HI=00000002 LO=fffffff2",
                     bus.HI_out, bus.LO_out);
        end
    endtask

    // Both starts together: MULT wins; a DivStart mid-operation is ignored.
    task automatic test_priority();
        int dones;
        int first;
        start_op(1'b1, 1'b1, 32'd6, 32'd4);
        dones = 0;
        first = 0;
        for (int i = 1; i <= 75; i++) begin
            @(posedge clk);
            #1;
            bus.DivStart = 1'b0;
            if (bus.MultDivDone === 1'b1) begin
                dones++;
                if (first == 0) begin
                    first = i;
                    checks++;
                    if (bus.HI_out !== 32'd0 || bus.LO_out !== 32'd24) begin
                        errors++;
                        $display("FAIL priority_result: got HI=%h LO=%h want HI=00000000 LO=00000018",
                                 bus.HI_out, bus.LO_out);
                    end
                end
            end
            if (i == 10) begin
                bus.DivStart = 1'b1;
                bus.A_in     = 32'd9;
                bus.B_in     = 32'd3;
            end
        end
        checks++;
        if (dones !== 1 || first !== 32) begin
            errors++;
            $display("FAIL priority_done: got %0d dones first at %0d want 1 at 32", dones, first);
        end
    endtask

    // Reset during iteration 15 of a MULT clears everything at once.
    task automatic test_reset_midop();
        int dones;
        start_op(1'b1, 1'b0, 32'd1000, 32'd1000);
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.HI_out !== 32'd0 || bus.LO_out !== 32'd0 || bus.Busy !== 1'b0 ||
            bus.MultDivDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: got HI=%h LO=%h busy=%b done=%b want 0",
                     bus.HI_out, bus.LO_out, bus.Busy, bus.MultDivDone);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (bus.MultDivDone === 1'b1 || bus.Busy === 1'b1)
                dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles want 0", dones);
        end
        run_op("mult_after_reset", 1'b1, 32'd3, 32'd5, 32'd0, 32'd15);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_priority();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
